packet_cmd: RTL and testbench

PACKET_CMD -- requirements
Module: packet_cmd

---
 rtl/packet_cmd.sv | 153 +++++++++++++++
 tb/tb_packet_cmd.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_cmd.sv
// Packet command engine: reads a "GF" packet out of the receiver's packet RAM
// and replays its 3-byte commands as register-bus writes, then handshakes.
module packet_cmd (
    input  logic        clk_cpu,
    input  logic        clk_cpu_reset,
    input  logic        eth_rx_ready,
    output logic        eth_rx_read,
    output logic [5:0]  ram_addr,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic [15:0] pkt_count,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {IDLE, HDR, CMD, ACK} state_t;

    state_t      state_q;
    logic [1:0]  sync_q;
    logic        ready_s;
    logic        rx_read_q;
    logic [5:0]  addr_q;
    logic [5:0]  lim_q;
    logic [1:0]  ph_q;
    logic [4:0]  left_q;
    logic [7:0]  b0_q;
    logic [7:0]  b1_q;
    logic [7:0]  reg_addr_q;
    logic [15:0] reg_wdata_q;
    logic        reg_we_q;
    logic [15:0] pkt_q;
    logic [7:0]  err_q;

    logic        hdr_bad_d;
    logic [5:0]  lim_d;
    logic [5:0]  addr_inc_d;
    logic [7:0]  err_d;

    assign ready_s = sync_q[1];

    always_comb begin
        hdr_bad_d  = (b0_q != 8'h47) || (b1_q != 8'h46) || (ram_rdata > 8'd20);
        // One address past the last command byte: the single allowed prefetch.
        lim_d      = ram_rdata[5:0] * 6'd3 + 6'd3;
        addr_inc_d = (addr_q != lim_q) ? addr_q + 6'd1 : addr_q;
        err_d      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    end

    always_ff @(posedge clk_cpu) begin
        if (clk_cpu_reset) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            rx_read_q   <= 1'b0;
            addr_q      <= '0;
            lim_q       <= '0;
            ph_q        <= '0;
            left_q      <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            pkt_q       <= '0;
            err_q       <= '0;
        end else begin
            sync_q   <= {sync_q[0], eth_rx_ready};
            reg_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Address 0 is already on the bus here, so byte 0 arrives in HDR's first cycle.
                    addr_q <= '0;
                    ph_q   <= '0;
                    if (ready_s) begin
                        state_q <= HDR;
                        addr_q  <= 6'd1;
                    end
                end
                HDR: begin
                    addr_q <= addr_q + 6'd1;
                    ph_q   <= ph_q + 2'd1;
                    case (ph_q)
                        2'd0:    b0_q <= ram_rdata;
                        2'd1:    b1_q <= ram_rdata;
                        default: begin
                            if (hdr_bad_d) begin
                                err_q     <= err_d;
                                state_q   <= ACK;
                                rx_read_q <= 1'b1;
                                addr_q    <= '0;
                            end else if (ram_rdata == 8'd0) begin
                                pkt_q     <= pkt_q + 16'd1;
                                state_q   <= ACK;
                                rx_read_q <= 1'b1;
                                addr_q    <= '0;
                            end else begin
                                state_q <= CMD;
                                left_q  <= ram_rdata[4:0];
                                lim_q   <= lim_d;
                                ph_q    <= '0;
                            end
                        end
                    endcase
                end
                CMD: begin
                    if (ph_q == 2'd3) begin
                        // Last write has just been presented; stay in CMD for it, then acknowledge.
                        state_q   <= ACK;
                        pkt_q     <= pkt_q + 16'd1;
                        rx_read_q <= 1'b1;
                        addr_q    <= '0;
                    end else begin
                        addr_q <= addr_inc_d;
                        case (ph_q)
                            2'd0: begin
                                b0_q <= ram_rdata;
                                ph_q <= 2'd1;
                            end
                            2'd1: begin
                                b1_q <= ram_rdata;
                                ph_q <= 2'd2;
                            end
                            default: begin
                                reg_we_q    <= 1'b1;
                                reg_addr_q  <= b0_q;
                                reg_wdata_q <= {b1_q, ram_rdata};
                                left_q      <= left_q - 5'd1;
                                ph_q        <= (left_q == 5'd1) ? 2'd3 : 2'd0;
                            end
                        endcase
                    end
                end
                ACK: begin
                    addr_q <= '0;
                    if (!ready_s) begin
                        rx_read_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign eth_rx_read = rx_read_q;
    assign ram_addr    = addr_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_we      = reg_we_q;
    assign pkt_count   = pkt_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_packet_cmd.sv
// Directed bench for packet_cmd: a packet-level model schedules the expected
// register writes and counters; a negedge process compares every cycle.
module tb_packet_cmd;

    logic        clk_cpu = 1'b0;
    logic        clk_cpu_reset;
    logic        eth_rx_ready;
    logic        eth_rx_read;
    logic [5:0]  ram_addr;
    logic [7:0]  ram_rdata;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;

    packet_cmd dut (
        .clk_cpu       (clk_cpu),
        .clk_cpu_reset (clk_cpu_reset),
        .eth_rx_ready  (eth_rx_ready),
        .eth_rx_read   (eth_rx_read),
        .ram_addr      (ram_addr),
        .ram_rdata     (ram_rdata),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_we        (reg_we),
        .pkt_count     (pkt_count),
        .err_count     (err_count)
    );

    always #5 clk_cpu = ~clk_cpu;

    logic [7:0] mem [64];
    always @(posedge clk_cpu) ram_rdata <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk_cpu) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         sched[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          addr_max = 0;
    logic [15:0] m_pkt    = '0;
    logic [7:0]  m_err    = '0;
    logic        cmp_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of the write stream and the RAM address bound.
    always @(negedge clk_cpu) begin
        while (sched.size() > 0 && sched[0].cyc < cyc) void'(sched.pop_front());
        cmp_we = (sched.size() > 0) && (sched[0].cyc == cyc);
        chk("reg_we", reg_we, cmp_we);
        if (cmp_we) begin
            chk("reg_addr", reg_addr, sched[0].a);
            chk("reg_wdata", reg_wdata, sched[0].d);
            void'(sched.pop_front());
        end
        chk("ram_addr_bound", (ram_addr <= addr_max), 1);
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    endtask

    task automatic set_hdr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] n);
        clear_mem();
        mem[0] = b0;
        mem[1] = b1;
        mem[2] = n;
    endtask

    task automatic set_cmd(input int k, input logic [7:0] a, input logic [15:0] d);
        mem[3 + 3 * k] = a;
        mem[4 + 3 * k] = d[15:8];
        mem[5 + 3 * k] = d[7:0];
    endtask

    // Model: ready rises between edge r and r+1; writes land 9+3i edges later.
    task automatic start_pkt(input int r, output int done);
        int n;
        n = mem[2];
        if (mem[0] == 8'h47 && mem[1] == 8'h46 && n <= 20) begin
            for (int i = 0; i < n; i++)
                sched.push_back('{r + 9 + 3 * i, mem[3 + 3 * i], {mem[4 + 3 * i], mem[5 + 3 * i]}});
            addr_max = 3 * n + 3;
            done     = (n == 0) ? r + 6 : r + 7 + 3 * n;
            m_pkt    = m_pkt + 16'd1;
        end else begin
            addr_max = 3;
            done     = r + 6;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
    endtask

    task automatic finish_pkt(input int done, input int hold);
        int l;
        while (cyc < done - 1) @(negedge clk_cpu);
        chk("rx_read_before_ack", eth_rx_read, 0);
        @(negedge clk_cpu);
        chk("rx_read_ack", eth_rx_read, 1);
        chk("pkt_count", pkt_count, m_pkt);
        chk("err_count", err_count, m_err);
        repeat (hold) @(negedge clk_cpu);
        chk("rx_read_hold", eth_rx_read, 1);
        eth_rx_ready = 1'b0;
        l = cyc;
        while (cyc < l + 2) @(negedge clk_cpu);
        chk("rx_read_sync_delay", eth_rx_read, 1);
        @(negedge clk_cpu);
        chk("rx_read_release", eth_rx_read, 0);
        chk("pkt_count_idle", pkt_count, m_pkt);
        chk("err_count_idle", err_count, m_err);
        repeat (3) @(negedge clk_cpu);
    endtask

    task automatic run_pkt(input int hold);
        int done;
        start_pkt(cyc, done);
        eth_rx_ready = 1'b1;
        finish_pkt(done, hold);
    endtask

    task automatic chk_reset_state();
        chk("rst_rx_read", eth_rx_read, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_err_count", err_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        int done;
        clk_cpu_reset = 1'b1;
        eth_rx_ready  = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk_cpu);
        chk_reset_state();
        clk_cpu_reset = 1'b0;
        repeat (2) @(negedge clk_cpu);

        // Two-command packet with literal timing and payload checks.
        set_hdr(8'h47, 8'h46, 8'h02);
        set_cmd(0, 8'h10, 16'h1234);
        set_cmd(1, 8'h11, 16'hABCD);
        r = cyc;
        start_pkt(r, done);
        eth_rx_ready = 1'b1;
        while (cyc < r + 8) @(negedge clk_cpu);
        chk("first_we_not_early", reg_we, 0);
        @(negedge clk_cpu);
        chk("first_we", reg_we, 1);
        chk("first_addr", reg_addr, 8'h10);
        chk("first_data", reg_wdata, 16'h1234);
        while (cyc < r + 12) @(negedge clk_cpu);
        chk("second_we", reg_we, 1);
        chk("second_addr", reg_addr, 8'h11);
        chk("second_data", reg_wdata, 16'hABCD);
        finish_pkt(done, 5);
        chk("pkt_after_two_cmds", pkt_count, 1);

        // Bad magic.
        set_hdr(8'h47, 8'h00, 8'h02);
        run_pkt(2);
        chk("err_after_bad_magic", err_count, 1);

        // N one above the limit.
        set_hdr(8'h47, 8'h46, 8'd21);
        run_pkt(1);
        chk("err_after_n21", err_count, 2);

        // N at the limit; last command occupies bytes 60..62.
        set_hdr(8'h47, 8'h46, 8'd20);
        for (int k = 0; k < 20; k++) set_cmd(k, 8'h20 + 8'(k), {8'(k), 8'hA0 + 8'(k)});
        r = cyc;
        start_pkt(r, done);
        eth_rx_ready = 1'b1;
        while (cyc < r + 66) @(negedge clk_cpu);
        chk("last_we_n20", reg_we, 1);
        chk("last_addr_n20", reg_addr, 8'h33);
        chk("last_data_n20", reg_wdata, 16'h13B3);
        finish_pkt(done, 0);
        chk("pkt_after_n20", pkt_count, 2);

        // Empty packet.
        set_hdr(8'h47, 8'h46, 8'h00);
        run_pkt(1);
        chk("pkt_after_n0", pkt_count, 3);

        // Reset after the first write of a 3-command packet, ready held high.
        set_hdr(8'h47, 8'h46, 8'h03);
        set_cmd(0, 8'h20, 16'h0001);
        set_cmd(1, 8'h21, 16'h0002);
        set_cmd(2, 8'h22, 16'h0003);
        r = cyc;
        start_pkt(r, done);
        eth_rx_ready = 1'b1;
        while (cyc < r + 9) @(negedge clk_cpu);
        chk("pre_reset_we", reg_we, 1);
        chk("pre_reset_addr", reg_addr, 8'h20);
        @(negedge clk_cpu);
        clk_cpu_reset = 1'b1;
        sched.delete();
        m_pkt = '0;
        m_err = '0;
        @(negedge clk_cpu);
        chk_reset_state();
        clk_cpu_reset = 1'b0;
        start_pkt(cyc, done);
        finish_pkt(done, 1);
        chk("pkt_after_reissue", pkt_count, 1);

        // Ready held high in ACK: one packet, one count.
        set_hdr(8'h47, 8'h46, 8'h02);
        set_cmd(0, 8'h10, 16'h1234);
        set_cmd(1, 8'h11, 16'hABCD);
        run_pkt(50);
        repeat (20) @(negedge clk_cpu);
        chk("pkt_after_long_hold", pkt_count, 2);

        // Reset while acknowledging drops the acknowledge at once.
        set_hdr(8'h47, 8'h46, 8'h00);
        r = cyc;
        start_pkt(r, done);
        eth_rx_ready = 1'b1;
        while (cyc < done) @(negedge clk_cpu);
        chk("ack_before_reset", eth_rx_read, 1);
        clk_cpu_reset = 1'b1;
        eth_rx_ready  = 1'b0;
        m_pkt = '0;
        m_err = '0;
        @(negedge clk_cpu);
        chk("ack_dropped_by_reset", eth_rx_read, 0);
        chk("pkt_cleared_by_reset", pkt_count, 0);
        clk_cpu_reset = 1'b0;
        repeat (5) @(negedge clk_cpu);
        chk("ack_stays_low", eth_rx_read, 0);

        // Drive the error counter to saturation and past it.
        set_hdr(8'h00, 8'h46, 8'h01);
        while (m_err != 8'hFF) run_pkt(0);
        chk("err_at_255", err_count, 255);
        repeat (3) run_pkt(0);
        chk("err_saturated", err_count, 255);
        chk("pkt_untouched_by_errors", pkt_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
